// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the host command parser.
// States, ASCII codes and default field widths.
package cmd_parser_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SP1,
      S_ID,
      S_IDX,
      S_VAL,
      S_EMIT,
      S_TNL,
      S_SKIP
   } state_t;

   localparam logic [7:0] A_B  = 8'h62;
   localparam logic [7:0] A_F  = 8'h66;
   localparam logic [7:0] A_T  = 8'h74;
   localparam logic [7:0] A_H  = 8'h68;
   localparam logic [7:0] A_SP = 8'h20;
   localparam logic [7:0] A_NL = 8'h0a;
   localparam logic [7:0] A_0  = 8'h30;
   localparam logic [7:0] A_1  = 8'h31;
   localparam logic [7:0] A_9  = 8'h39;

   localparam int IDW_D  = 2;
   localparam int IDXW_D = 8;
   localparam int VALW_D = 64;
   localparam int ERRW_D = 8;

endpackage

// File: rtl/field_accum.sv
// Numeric field accumulator: binary shift-in or decimal x10+d.
// ovf flags that the presented digit would not fit the field.
module field_accum #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         stb,
   input  logic [3:0]   digit,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         seen,
   output logic         ovf
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CMAX = CW'(W);

   logic [CW-1:0] cnt;
   logic [W+3:0]  ext;
   logic [W+3:0]  prod;

   // Next decimal value computed wide so overflow is visible.
   always_comb begin
      ext  = {4'b0000, value};
      prod = (ext << 3) + (ext << 1) + {{W{1'b0}}, digit};
      ovf  = dec ? (|prod[W+3:W]) : (cnt == CMAX);
   end

   // Accumulate one digit per strobe; clear wins.
   always_ff @(posedge clk) begin
      if (clear) begin
         value <= '0;
         seen  <= 1'b0;
         cnt   <= '0;
      end else if (stb) begin
         value <= dec ? prod[W-1:0] : {value[W-2:0], digit[0]};
         seen  <= 1'b1;
         if (cnt != CMAX)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cmd_parser.sv
// Host command byte-stream parser.
// Decodes b/f writes, t ticks and h comment lines.
module cmd_parser
   import cmd_parser_pkg::*;
#(
   parameter int IDW  = IDW_D,
   parameter int IDXW = IDXW_D,
   parameter int VALW = VALW_D,
   parameter int ERRW = ERRW_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      byte_in,
   input  logic            byte_valid,
   output logic            byte_ready,
   output logic            wr_valid,
   input  logic            wr_ready,
   output logic            wr_float,
   output logic [IDW-1:0]  wr_id,
   output logic [IDXW-1:0] wr_index,
   output logic [VALW-1:0] wr_value,
   output logic            tick,
   output logic            err_pulse,
   output logic [ERRW-1:0] err_count
);

   state_t state;

   logic accept, is_dig, is_bin, is_cmd;
   logic clr, id_stb, idx_stb, val_stb, bad;
   logic id_seen, idx_seen, val_seen;
   logic id_ovf, idx_ovf, val_ovf;

   assign accept = byte_valid & byte_ready;
   assign is_dig = (byte_in >= A_0) && (byte_in <= A_9);
   assign is_bin = (byte_in == A_0) || (byte_in == A_1);
   assign is_cmd = (byte_in == A_B) || (byte_in == A_F);

   // Classify the accepted byte: digit strobes or malformed.
   always_comb begin
      clr     = rst;
      id_stb  = 1'b0;
      idx_stb = 1'b0;
      val_stb = 1'b0;
      bad     = 1'b0;
      if (accept && !rst) begin
         case (state)
            S_IDLE: begin
               unique case (1'b1)
                  is_cmd:             clr = 1'b1;
                  (byte_in == A_T):   ;
                  (byte_in == A_H):   ;
                  (byte_in == A_NL):  ;
                  default:            bad = 1'b1;
               endcase
            end
            S_SP1: bad = (byte_in != A_SP);
            S_ID: begin
               if (is_bin) begin
                  bad    = id_ovf;
                  id_stb = !id_ovf;
               end else if (byte_in == A_SP)
                  bad = !id_seen;
               else
                  bad = 1'b1;
            end
            S_IDX: begin
               if (is_dig) begin
                  bad     = idx_ovf;
                  idx_stb = !idx_ovf;
               end else if (byte_in == A_SP)
                  bad = !idx_seen;
               else
                  bad = 1'b1;
            end
            S_VAL: begin
               if (wr_float ? is_dig : is_bin) begin
                  bad     = !wr_float && val_ovf;
                  val_stb = !bad;
               end else if (byte_in == A_NL)
                  bad = !val_seen;
               else
                  bad = 1'b1;
            end
            S_TNL: bad = (byte_in != A_NL);
            default: ;
         endcase
      end
   end

   field_accum #(.W(IDW)) u_id (
      .clk   (clk),
      .clear (clr),
      .stb   (id_stb),
      .digit (byte_in[3:0]),
      .dec   (1'b0),
      .value (wr_id),
      .seen  (id_seen),
      .ovf   (id_ovf)
   );

   field_accum #(.W(IDXW)) u_idx (
      .clk   (clk),
      .clear (clr),
      .stb   (idx_stb),
      .digit (byte_in[3:0]),
      .dec   (1'b1),
      .value (wr_index),
      .seen  (idx_seen),
      .ovf   (idx_ovf)
   );

   field_accum #(.W(VALW)) u_val (
      .clk   (clk),
      .clear (clr),
      .stb   (val_stb),
      .digit (byte_in[3:0]),
      .dec   (wr_float),
      .value (wr_value),
      .seen  (val_seen),
      .ovf   (val_ovf)
   );

   // Parser FSM with registered handshake, tick and error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_ready <= 1'b1;
         wr_valid   <= 1'b0;
         wr_float   <= 1'b0;
         tick       <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (accept && bad) begin
            err_pulse <= 1'b1;
            if (err_count != '1)
               err_count <= err_count + 1'b1;
            state <= (byte_in == A_NL) ? S_IDLE : S_SKIP;
         end else if (accept) begin
            case (state)
               S_IDLE: begin
                  unique case (1'b1)
                     is_cmd: begin
                        wr_float <= (byte_in == A_F);
                        state    <= S_SP1;
                     end
                     (byte_in == A_T): state <= S_TNL;
                     (byte_in == A_H): state <= S_SKIP;
                     default: ;
                  endcase
               end
               S_SP1: state <= S_ID;
               S_ID:
                  if (byte_in == A_SP)
                     state <= S_IDX;
               S_IDX:
                  if (byte_in == A_SP)
                     state <= S_VAL;
               S_VAL:
                  if (byte_in == A_NL) begin
                     state      <= S_EMIT;
                     wr_valid   <= 1'b1;
                     byte_ready <= 1'b0;
                  end
               S_TNL: begin
                  tick  <= ~tick;
                  state <= S_IDLE;
               end
               S_SKIP:
                  if (byte_in == A_NL)
                     state <= S_IDLE;
               default: ;
            endcase
         end else if (state == S_EMIT && wr_ready) begin
            wr_valid   <= 1'b0;
            byte_ready <= 1'b1;
            state      <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser.
// Byte-level stimulus with hand-computed expectations.
module tb_cmd_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        wr_valid;
   logic        wr_ready = 1'b1;
   logic        wr_float;
   logic [1:0]  wr_id;
   logic [7:0]  wr_index;
   logic [63:0] wr_value;
   logic        tick;
   logic        err_pulse;
   logic [7:0]  err_count;

   int checks = 0;
   int failures = 0;
   int nwr = 0;
   int nerr = 0;

   cmd_parser dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_float   (wr_float),
      .wr_id      (wr_id),
      .wr_index   (wr_index),
      .wr_value   (wr_value),
      .tick       (tick),
      .err_pulse  (err_pulse),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Count completed writes and error strobes between edges.
   always @(negedge clk) begin
      if (wr_valid && wr_ready)
         nwr++;
      if (err_pulse)
         nerr++;
   end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready)
         check("send_timeout", 64'(byte_ready), 64'd1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         send(s[i]);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check("rst_byte_ready", 64'(byte_ready), 64'd1);
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_tick", 64'(tick), 64'd0);
      check("rst_err_pulse", 64'(err_pulse), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      check("rst_wr_value", wr_value, 64'd0);

      send_str("b 01 3 1\n");
      check("b1_valid", 64'(wr_valid), 64'd1);
      check("b1_ready", 64'(byte_ready), 64'd0);
      check("b1_float", 64'(wr_float), 64'd0);
      check("b1_id", 64'(wr_id), 64'd1);
      check("b1_index", 64'(wr_index), 64'd3);
      check("b1_value", wr_value, 64'd1);
      step();
      check("b1_drop", 64'(wr_valid), 64'd0);
      check("b1_ready_back", 64'(byte_ready), 64'd1);
      check("b1_nwr", 64'(nwr), 64'd1);
      check("b1_errs", 64'(err_count), 64'd0);

      send_str("f 10 1 18446744073709551617\n");
      check("f1_valid", 64'(wr_valid), 64'd1);
      check("f1_float", 64'(wr_float), 64'd1);
      check("f1_id", 64'(wr_id), 64'd2);
      check("f1_index", 64'(wr_index), 64'd1);
      check("f1_value_wrap", wr_value, 64'd1);
      step();
      check("f1_nwr", 64'(nwr), 64'd2);

      send_str("t\n");
      check("tick_1", 64'(tick), 64'd1);
      check("tick_1_novalid", 64'(wr_valid), 64'd0);
      send_str("t\n");
      check("tick_0", 64'(tick), 64'd0);
      check("tick_nwr", 64'(nwr), 64'd2);

      send_str("b 01");
      send("1");
      check("id_ovf_pulse", 64'(err_pulse), 64'd1);
      send_str(" 0 1\n");
      check("id_ovf_count", 64'(err_count), 64'd1);
      send_str("b 00 30");
      send("0");
      check("idx_ovf_pulse", 64'(err_pulse), 64'd1);
      send_str(" 1\n");
      check("idx_ovf_count", 64'(err_count), 64'd2);
      check("err_nwr", 64'(nwr), 64'd2);
      check("err_no_valid", 64'(wr_valid), 64'd0);

      send_str("b 00 5 0\n");
      check("b2_valid", 64'(wr_valid), 64'd1);
      check("b2_float", 64'(wr_float), 64'd0);
      check("b2_id", 64'(wr_id), 64'd0);
      check("b2_index", 64'(wr_index), 64'd5);
      check("b2_value", wr_value, 64'd0);
      step();
      check("b2_nwr", 64'(nwr), 64'd3);

      wr_ready = 1'b0;
      send_str("f 00 0 42\n");
      byte_in    = "t";
      byte_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(wr_valid), 64'd1);
         check("bp_ready", 64'(byte_ready), 64'd0);
         check("bp_value", wr_value, 64'd42);
         check("bp_float", 64'(wr_float), 64'd1);
         step();
      end
      check("bp_tick_held", 64'(tick), 64'd0);
      wr_ready = 1'b1;
      step();
      check("bp_drop", 64'(wr_valid), 64'd0);
      check("bp_ready_back", 64'(byte_ready), 64'd1);
      check("bp_nwr", 64'(nwr), 64'd4);
      step();
      byte_valid = 1'b0;
      send(8'h0a);
      check("bp_next_byte_tick", 64'(tick), 64'd1);

      send_str("f 01 2 7");
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 64'(wr_valid), 64'd0);
      check("mid_rst_errs", 64'(err_count), 64'd0);
      check("mid_rst_tick", 64'(tick), 64'd0);
      send_str("h xyz\n");
      send_str("t\n");
      check("post_rst_errs", 64'(err_count), 64'd0);
      check("post_rst_tick", 64'(tick), 64'd1);
      step();
      check("total_nwr", 64'(nwr), 64'd4);
      check("total_err_pulses", 64'(nerr), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Upstream front end for the component controller. Takes the host command byte stream one ASCII byte per handshake.
- Parses the command grammar: "b <id> <index> <value>\n", "f <id> <index> <value>\n", "t\n" and "h...\n".
- Emits one decoded write transaction per command on a valid/ready port, and toggles the server tick level.
- Replaces the behavioural $fgetc/$fscanf front end with synthesizable RTL feeding the airflow/thrusters/solar update path.

Parameters:
- IDW, 2: component id width; id field is binary digits.
- IDXW, 8: index width; index field is decimal.
- VALW, 64: value width; value is binary digits for 'b', decimal for 'f'.
- ERRW, 8: error counter width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  ASCII byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  parser accepts byte_in this cycle.
- wr_valid  out  1  decoded write available.
- wr_ready  in  1  consumer takes the write.
- wr_float  out  1  0 = binary write ('b'), 1 = float write ('f').
- wr_id  out  IDW  component id.
- wr_index  out  IDXW  variable index.
- wr_value  out  VALW  value.
- tick  out  1  server tick level; toggles once per accepted "t\n".
- err_pulse  out  1  one-cycle strobe when a malformed command is detected.
- err_count  out  ERRW  saturating count of malformed commands.

Behaviour:
- Reset:
  - Clock and reset are one clock, clk; rst is synchronous and active-high.
  - All outputs are 0 except byte_ready = 1.
  - State is S_IDLE and all accumulators are cleared.
  - Reset asserted mid-command discards the partial command with no write, no error and no tick change. A pending wr_valid is dropped.
- Byte acceptance: a byte is consumed on a cycle where byte_valid and byte_ready are both high. byte_ready is 0 only in S_EMIT.
- States:
  - S_IDLE:
    - 'b' or 'f': latch wr_float, clear accumulators, go to S_SP1.
    - 't': go to S_TNL.
    - 'h': go to S_SKIP, with no error.
    - '\n': stay (empty line ignored).
    - Any other byte: error.
  - S_SP1: ' ' goes to S_ID; else error.
  - S_ID:
    - '0'/'1': shift into id.
    - ' ' with at least one digit: go to S_IDX.
    - More than IDW digits, a space with no digit, or any other byte: error.
  - S_IDX:
    - '0'-'9': idx = idx*10 + d.
    - Result above 2^IDXW-1: error.
    - ' ' with at least one digit: go to S_VAL; else error.
  - S_VAL:
    - Binary mode: accept only '0'/'1'; shift in; more than VALW digits is an error.
    - Decimal mode: accept '0'-'9'; val = val*10 + d modulo 2^VALW (wraps, no error).
    - '\n' with at least one digit: go to S_EMIT; else error.
  - S_EMIT:
    - wr_valid = 1 starting the cycle after '\n' is accepted (latency 1).
    - wr_* fields are held stable while wr_valid is high.
    - On wr_valid & wr_ready: wr_valid drops next cycle, go to S_IDLE.
    - No bytes are accepted in this state.
  - S_TNL: '\n' toggles tick on the next edge and returns to S_IDLE; any other byte is an error.
  - S_SKIP: discard bytes until '\n', then go to S_IDLE.
- Error:
  - err_pulse is high for exactly the cycle after the offending byte is accepted.
  - err_count increments and saturates at 2^ERRW-1.
  - If the offending byte is '\n', go to S_IDLE; otherwise go to S_SKIP.
- Simultaneous events: wr_ready is ignored unless wr_valid. Error and tick never coincide.
- No write is produced for a command containing any error.

Decomposition:
- Package cmd_parser_pkg:
  - State encodings S_IDLE..S_SKIP (4-bit).
  - ASCII constants for 'b', 'f', 't', 'h', ' ', '\n', '0', '9'.
  - Default IDW/IDXW/VALW.
- Sub-module field_accum (parameter W):
  - Ports: clear, digit strobe, 4-bit digit, radix-decimal select.
  - Outputs: accumulated value, digit-seen flag, overflow flag.
  - Handles both binary shift and x10+d.
  - Instantiated three times: id, index, value.

Test Plan:
- Bytes "b 01 3 1\n" with wr_ready = 1: one wr_valid cycle with wr_float = 0, wr_id = 01, wr_index = 3, wr_value = 1; err_count stays 0.
- "f 10 1 18446744073709551617\n": wr_float = 1, wr_id = 10, wr_index = 1, wr_value = 1 (wraps mod 2^64).
- "t\n" twice: tick goes 0→1 one cycle after the first '\n', then back to 0 after the second; no wr_valid.
- "b 011 0 1\n" then "b 00 300 1\n": two err_pulses, err_count = 2, no writes; a following "b 00 5 0\n" decodes correctly.
- Emit backpressure: hold wr_ready = 0 for 10 cycles after "f 00 0 42\n". wr_valid and fields are held and byte_ready = 0 throughout. The write completes when wr_ready rises, then the next byte is accepted.
- Assert rst after "f 01 2 7" without '\n': no write and no error. A following "h xyz\n" then "t\n" leaves err_count at 0 and tick at 1.
